// File: rtl/stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// stream_demux_1to2
//
// Registered 1:2 stream demultiplexer with valid/ready handshakes. Each input
// beat is steered to one of two output ports. Each output port has its own
// one-entry {valid, data} register, so a stalled consumer only blocks beats
// that are routed to it.
//
// Optional feature (compile-time macro):
//   STREAM_DEMUX_PKT_LOCK_EN - packet-lock mode. The first beat of a packet
//   selects the destination, and every later beat of that packet follows it
//   until the beat with s_last = 1. When the macro is undefined, every beat
//   routes on its own s_sel and s_last is ignored.
//
// Parameters:
//   WIDTH    - payload width of every port
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst_n    - asynchronous active-low reset
//   s_valid  - input beat valid
//   s_ready  - block can accept the input beat (combinational)
//   s_data   - input payload
//   s_sel    - destination select: 0 = port 0, 1 = port 1
//   s_last   - last beat of a packet (used only in packet-lock mode)
//   m0_*     - output port 0 valid/ready/data
//   m1_*     - output port 1 valid/ready/data
// -----------------------------------------------------------------------------
module stream_demux_1to2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_sel,
    input  logic             s_last,

    output logic             m0_valid,
    input  logic             m0_ready,
    output logic [WIDTH-1:0] m0_data,

    output logic             m1_valid,
    input  logic             m1_ready,
    output logic [WIDTH-1:0] m1_data
);

    // Routed port for the current input beat.
    logic             rsel;
    logic             accept;

    logic             m0_valid_q;
    logic             m0_valid_d;
    logic [WIDTH-1:0] m0_data_q;
    logic [WIDTH-1:0] m0_data_d;

    logic             m1_valid_q;
    logic             m1_valid_d;
    logic [WIDTH-1:0] m1_data_q;
    logic [WIDTH-1:0] m1_data_d;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    // -------------------------------------------------------------------------
    // Packet-lock FSM: IDLE follows s_sel; LOCKx pins the route to port x
    // until the packet's last beat is accepted.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    always_comb begin
        rsel = s_sel;
        case (state_q)
            LOCK0:   rsel = 1'b0;
            LOCK1:   rsel = 1'b1;
            default: rsel = s_sel;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A single-beat packet (s_last on the first beat) never locks.
                if (accept && !s_last) begin
                    state_d = s_sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`else
    // -------------------------------------------------------------------------
    // Per-beat routing: no packet state, s_last has no effect.
    // -------------------------------------------------------------------------
    logic unused_s_last;

    always_comb begin
        unused_s_last = s_last;
        rsel          = s_sel;
    end
`endif

    // -------------------------------------------------------------------------
    // Input handshake: ready only depends on the register of the routed port,
    // so a full, stalled register on the other port never blocks this beat.
    // -------------------------------------------------------------------------
    always_comb begin
        if (rsel) begin
            s_ready = !m1_valid_q || m1_ready;
        end else begin
            s_ready = !m0_valid_q || m0_ready;
        end
        accept = s_valid && s_ready;
    end

    // -------------------------------------------------------------------------
    // Output registers. A load wins over a drain so that load-and-drain in the
    // same cycle keeps valid high with the new payload (no bubble). Data is
    // never cleared on drain; it simply holds until the next load.
    // -------------------------------------------------------------------------
    always_comb begin
        m0_valid_d = m0_valid_q;
        m0_data_d  = m0_data_q;
        if (accept && !rsel) begin
            m0_valid_d = 1'b1;
            m0_data_d  = s_data;
        end else if (m0_valid_q && m0_ready) begin
            m0_valid_d = 1'b0;
        end
    end

    always_comb begin
        m1_valid_d = m1_valid_q;
        m1_data_d  = m1_data_q;
        if (accept && rsel) begin
            m1_valid_d = 1'b1;
            m1_data_d  = s_data;
        end else if (m1_valid_q && m1_ready) begin
            m1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_valid_q <= 1'b0;
            m0_data_q  <= '0;
            m1_valid_q <= 1'b0;
            m1_data_q  <= '0;
        end else begin
            m0_valid_q <= m0_valid_d;
            m0_data_q  <= m0_data_d;
            m1_valid_q <= m1_valid_d;
            m1_data_q  <= m1_data_d;
        end
    end

    always_comb begin
        m0_valid = m0_valid_q;
        m0_data  = m0_data_q;
        m1_valid = m1_valid_q;
        m1_data  = m1_data_q;
    end

endmodule

// File: doc/stream_demux_1to2.md
# stream_demux_1to2

Registered 1:2 stream demultiplexer with valid/ready handshakes. It routes each input beat to one of two output ports, chosen by a select bit, with one register stage per output. It is the fan-out counterpart to the 2:1 select mux in the datapath: a producer feeds one stream, and the block steers it to either of two consumers. Backpressure on one output never stalls traffic bound for the other output once the current beat has moved.

## Interface
Parameters:
- WIDTH, default 8, data width of every port.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept the input beat.
- s_data  in  WIDTH  input payload.
- s_sel  in  1  destination: 0 = port 0, 1 = port 1.
- s_last  in  1  last beat of packet; only meaningful with packet lock compiled in.
- m0_valid / m1_valid  out  1  output beat valid.
- m0_ready / m1_ready  in  1  downstream accepts.
- m0_data / m1_data  out  WIDTH  output payload.

## Operation
- Each output has a one-entry register holding {valid, data}.
- An output register loads when an input beat is accepted and the beat routes to that port.
- An output register clears valid when m*_valid and m*_ready are both high and no new load happens in the same cycle.
- Load and drain in the same cycle: the register takes the new data and valid stays 1 (full throughput).
- Routed port, rsel: s_sel in per-beat mode; the locked select in packet-lock mode.
- s_ready = !mX_valid || mX_ready, where X = rsel. This is combinational on the handshake inputs and s_sel.
- Accept condition: s_valid && s_ready.
- The non-routed output register is unaffected by an accept.
- m*_data holds its last value when valid is low. The value is not cleared on drain.
- The s_data to m*_data path is a pure copy with no width change.

## Timing
- Reset values: m0_valid = 0, m1_valid = 0, m0_data = 0, m1_data = 0, state = IDLE, lock register = 0.
- s_ready after reset is 1, because both output registers are empty.
- Latency: a beat accepted at edge N appears at m*_valid/m*_data immediately after edge N, so it is visible in cycle N+1.
- Throughput: 1 beat per cycle per port while the downstream holds ready high.
- Handshake rules:
  - Outputs obey AXI-stream rules. Once m*_valid rises, m*_valid and m*_data stay stable until accepted.
  - The block does not require s_valid to be stable, but a bench should drive it stable.
- Reset asserted mid-operation: both valids drop asynchronously, any held beats are discarded, and the FSM returns to IDLE.

## Configuration
- Macro: STREAM_DEMUX_PKT_LOCK_EN.
- Defined, packet-lock mode with FSM states IDLE, LOCK0, LOCK1:
  - In IDLE, rsel = s_sel.
  - An accepted beat with s_last = 0 moves the FSM to LOCK{s_sel}.
  - An accepted beat with s_last = 1 keeps the FSM in IDLE (single-beat packet).
  - In LOCKx, rsel = x, and s_sel is ignored.
  - An accepted beat with s_last = 1 returns the FSM to IDLE.
  - No other transitions.
- Undefined: no FSM, s_last is ignored, and every beat routes on its own s_sel (rsel = s_sel always).

## Test plan
- Reset, then stream 4 beats 0x11, 0x22, 0x33, 0x44 with s_sel = 0 and m0_ready = 1 -> m0 emits the same 4 beats in consecutive cycles one cycle later; m1_valid stays 0 throughout.
- m0 stall: m0_ready = 0, then send 0xA1 and 0xA2 with s_sel = 0 -> 0xA1 is held on m0 and s_ready = 0. Next send 0xB1 with s_sel = 1 -> s_ready = 1 and m1 shows 0xB1 while m0 still holds 0xA1.
- Lock mode: send a 3-beat packet with s_sel = 1, 0, 0 and s_last on beat 3 -> all 3 beats go to m1. Then a beat with s_sel = 0 -> m0.
  - The same stimulus without STREAM_DEMUX_PKT_LOCK_EN -> beat 1 goes to m1 and beats 2-3 go to m0.
- Single-beat packet in lock mode: s_sel = 1, s_last = 1 -> m1; the FSM stays IDLE; the next beat with s_sel = 0 -> m0.
- Drain and load in the same cycle: m1 holds 0x5A while m1_ready = 1 and a new 0x6B arrives for m1 -> m1_valid stays 1 and the data becomes 0x6B next cycle; no bubble.
- Reset mid-packet: assert rst_n = 0 while in LOCK1 with m1 holding 0x77 -> m1_valid = 0 immediately. After release, a beat with s_sel = 0 routes to m0.
